// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: bundle of the signals between the fetch queue and the
// rest of the core.
//   imem_*     : request/grant toward instruction memory, plus its in-order
//                response.
//   inst*      : valid/ready stream of fetched words toward decode.
//   redirect_* : flush and restart request from the branch unit.
// The master modport is the fetch queue. The slave modport is its
// environment: the memory, decode and the branch unit.
interface ifetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end.
// It owns the fetch PC and issues word requests to a pipelined imem. Each
// returned word is pushed, together with its PC, into a DEPTH-entry FIFO
// that feeds decode. A redirect flushes the FIFO. Responses that are still
// in flight at the redirect are counted, and are discarded as they return.
// Ports:
//   clk   : clock for all state.
//   rst_n : synchronous active-low reset.
//   bus   : ifetch_queue_if.master, carrying the imem request/response,
//           the decode stream and the redirect.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]             fetch_pc_q, fetch_pc_d;
  logic [31:0]             resp_pc_q, resp_pc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           out_q, out_d;
  logic [CW-1:0]           drop_q, drop_d;
  logic [AW-1:0]           head_q, head_d;
  logic [AW-1:0]           tail_q, tail_d;
  logic [DEPTH-1:0][31:0]  word_q;
  logic [DEPTH-1:0][31:0]  pc_q;

  logic [CW:0]   credit;
  logic          req, issue, rsp, push, pop;
  logic [31:0]   redir_pc;

  // Credit covers both buffered and in-flight words, so every response that
  // returns is guaranteed a free FIFO slot.
  assign credit   = {1'b0, cnt_q} + {1'b0, out_q};
  assign req      = rst_n & ~bus.redirect_valid & (credit < (CW+1)'(DEPTH));
  assign issue    = req & bus.imem_gnt;
  // A response that arrives with nothing outstanding is a protocol error and
  // is ignored.
  assign rsp      = bus.imem_rvalid & (out_q != '0);
  assign redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = rst_n & (cnt_q != '0);
  assign bus.inst       = word_q[head_q];
  assign bus.inst_pc    = pc_q[head_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    push       = 1'b0;
    pop        = 1'b0;
    // issue is forced low during a redirect, so this is also correct then.
    out_d      = out_q + CW'(issue) - CW'(rsp);
    if (bus.redirect_valid) begin
      // Flush the FIFO. Every word still in flight after this cycle belongs
      // to the old path and is dropped when it returns.
      cnt_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = out_q - CW'(rsp);
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
    end else begin
      pop = (cnt_q != '0) & bus.inst_ready;
      if (rsp) begin
        if (drop_q != '0) drop_d = drop_q - CW'(1);
        else              push   = 1'b1;
      end
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        tail_d    = tail_q + AW'(1);
      end
      if (pop) head_d = head_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      cnt_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      word_q     <= '0;
      pc_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      // The credit rule never lets a push land on the live head entry, so
      // inst and inst_pc hold while decode stalls.
      if (push) begin
        word_q[tail_q] <= bus.imem_rdata;
        pc_q[tail_q]   <= resp_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic w_rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_queue_if bus();
  ifetch_queue_if wbus();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .bus(wbus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: FIFO contents as a queue, with plain counters for
  // in-flight and to-be-dropped responses.
  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
  ent_t        m_fifo[$];
  int          m_out, m_drop;
  logic [31:0] m_fetch, m_resp;

  // Memory model: accepted addresses, each with its due cycle, returned in
  // order.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int    cyc = 0;
  int    lat = 1;
  bit    stray_en = 0;

  logic        s_req, s_vld, s_rv;
  logic [31:0] s_addr, s_inst, s_pc;

  task automatic m_reset();
    m_fifo.delete(); m_out = 0; m_drop = 0; m_fetch = 32'h0; m_resp = 32'h0;
  endtask

  task automatic mem_drive(output bit rv, output bit rvp);
    rv = 0; rvp = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rv = 1; rvp = 1; bus.imem_rdata = pend[0].addr ^ 32'hA5A5_0000;
    end else if (stray_en && pend.size() == 0 && $urandom_range(0, 9) == 0) begin
      rv = 1; bus.imem_rdata = $urandom;
    end else begin
      bus.imem_rdata = $urandom;
    end
    bus.imem_rvalid = rv;
  endtask

  task automatic step(input bit g, input bit r, input bit rd, input logic [31:0] rpc);
    bit rv, rvp, m_req, rsp;
    logic [31:0] wd;
    bus.imem_gnt = g; bus.inst_ready = r; bus.redirect_valid = rd; bus.redirect_pc = rpc;
    mem_drive(rv, rvp);
    #1;
    s_req = bus.imem_req; s_addr = bus.imem_addr; s_vld = bus.inst_valid;
    s_inst = bus.inst; s_pc = bus.inst_pc; s_rv = rv;
    m_req = !rd && (m_fifo.size() + m_out < DEPTH);
    chk("imem_req", s_req, m_req);
    chk("imem_addr", s_addr, m_fetch);
    chk("inst_valid", s_vld, m_fifo.size() != 0);
    if (m_fifo.size() != 0) begin
      chk("inst", s_inst, m_fifo[0].w);
      chk("inst_pc", s_pc, m_fifo[0].pc);
    end
    wd  = bus.imem_rdata;
    rsp = rv && (m_out > 0);
    if (rvp) void'(pend.pop_front());
    if (rd) begin
      m_fifo.delete();
      m_out  = m_out - int'(rsp);
      m_drop = m_out;
      m_fetch = {rpc[31:2], 2'b00};
      m_resp  = {rpc[31:2], 2'b00};
    end else begin
      if (m_fifo.size() != 0 && r) void'(m_fifo.pop_front());
      if (rsp) begin
        m_out--;
        if (m_drop > 0) m_drop--;
        else begin m_fifo.push_back('{m_resp, wd}); m_resp += 32'd4; end
      end
      if (m_req && g) begin
        pend.push_back('{m_fetch, cyc + lat});
        m_out++;
        m_fetch += 32'd4;
      end
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic do_reset(input int ncyc, input bit keep_pend);
    bit rv, rvp;
    for (int i = 0; i < ncyc; i++) begin
      rst_n = 1'b0;
      bus.imem_gnt = 1'($urandom); bus.inst_ready = 1'($urandom);
      bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
      mem_drive(rv, rvp);
      #1;
      chk("rst_req", bus.imem_req, 0);
      chk("rst_vld", bus.inst_valid, 0);
      if (rvp) void'(pend.pop_front());
      @(posedge clk); #1; cyc++;
    end
    rst_n = 1'b1;
    if (!keep_pend) pend.delete();
    m_reset();
  endtask

  logic [31:0] wa[$], wp[$];
  logic [31:0] wexp[3];
  logic        nrv;
  logic [31:0] nd;
  int          n_gnt;
  bit          found, stale;

  initial begin
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0; bus.inst_ready = 0;
    bus.redirect_valid = 0; bus.redirect_pc = 0;
    wbus.imem_gnt = 1; wbus.imem_rvalid = 0; wbus.imem_rdata = 0; wbus.inst_ready = 1;
    wbus.redirect_valid = 0; wbus.redirect_pc = 0;

    // Wrap: instance reset to FFFF_FFF8, memory answers one cycle after grant
    @(posedge clk); #1; w_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (wbus.imem_req) wa.push_back(wbus.imem_addr);
      if (wbus.inst_valid) wp.push_back(wbus.inst_pc);
      nrv = wbus.imem_req & wbus.imem_gnt; nd = wbus.imem_addr;
      @(posedge clk); #1;
      wbus.imem_rvalid = nrv; wbus.imem_rdata = nd;
    end
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
    chk("wrap_naddr", 32'(wa.size() >= 3), 1);
    chk("wrap_npc", 32'(wp.size() >= 3), 1);
    for (int k = 0; k < 3; k++) begin
      if (wa.size() > k) chk("wrap_addr", wa[k], wexp[k]);
      if (wp.size() > k) chk("wrap_pc", wp[k], wexp[k]);
    end

    // Reset state
    do_reset(2, 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_inst_pc", bus.inst_pc, 0);

    // 1: streaming
    lat = 1;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0, 0);
      if (i < 4) chk("s1_addr", s_addr, 32'(i * 4));
      if (i == 1) chk("s1_vld_early", s_vld, 0);
      if (i >= 2) begin
        chk("s1_vld", s_vld, 1);
        chk("s1_pc", s_pc, 32'((i - 2) * 4));
      end
      if (i == 2) chk("s1_inst", s_inst, 32'hA5A5_0000);
    end

    // 2: backpressure
    do_reset(1, 0);
    n_gnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0);
      n_gnt += int'(s_req);
    end
    chk("s2_grants", n_gnt, 4);
    chk("s2_req_full", s_req, 0);
    chk("s2_pc_hold", s_pc, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("s2_req_after_pop", s_req, 1);
    chk("s2_addr_after_pop", s_addr, 32'h10);
    step(1, 0, 0, 0);
    chk("s2_req_refull", s_req, 0);

    // 3: redirect with two requests in flight
    do_reset(1, 0);
    lat = 3;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h100);
    step(1, 1, 0, 0);
    chk("s3_req", s_req, 1);
    chk("s3_addr", s_addr, 32'h100);
    found = 0; stale = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_vld && !found) begin
        found = 1;
        chk("s3_first_pc", s_pc, 32'h100);
      end
      if (s_vld && (s_pc == 32'h0 || s_pc == 32'h4)) stale = 1;
      step(1, 1, 0, 0);
    end
    chk("s3_seen", 32'(found), 1);
    chk("s3_stale", 32'(stale), 0);

    // 4: grant stall and unaligned redirect
    do_reset(1, 0);
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("s4_req_stall", s_req, 1);
      chk("s4_addr_stall", s_addr, 0);
    end
    step(0, 1, 1, 32'h0000_0103);
    step(1, 1, 0, 0);
    chk("s4_addr_redir", s_addr, 32'h100);

    // 6a: reset with two FIFO entries and two requests outstanding
    do_reset(1, 0);
    lat = 3;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    do_reset(1, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      chk("s6_vld_after_rst", s_vld, 0);
      chk("s6_addr_after_rst", s_addr, 32'h0);
    end

    // 6b: redirect in the same cycle as rvalid and inst_ready
    do_reset(1, 0);
    lat = 2;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h200);
    chk("s6_vld_at_redir", s_vld, 1);
    chk("s6_rv_at_redir", s_rv, 1);
    found = 0;
    for (int i = 0; i < 15; i++) begin
      step(1, 1, 0, 0);
      if (s_vld && !found) begin
        found = 1;
        chk("s6_first_pc", s_pc, 32'h200);
        chk("s6_first_inst", s_inst, 32'h200 ^ 32'hA5A5_0000);
      end
    end
    chk("s6_seen", 32'(found), 1);

    // Random traffic against the model
    do_reset(1, 0);
    stray_en = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1, 1);
      else begin
        if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 4);
        step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
             $urandom_range(0, 24) == 0, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
